// File: rtl/lane_packer_if.sv
// Stream bundle around lane_packer: masked multi-lane input side and dense counted output side.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both high; payload holds while valid waits.
`timescale 1ns/1ps
interface lane_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4
);
   localparam int CW = $clog2(N + 1);

   logic [0:N-1][DATA_WIDTH-1:0] in_data;
   logic [N-1:0]                 in_mask;
   logic                         in_last;
   logic                         in_valid;
   logic                         in_ready;
   logic [0:N-1][DATA_WIDTH-1:0] out_data;
   logic [CW-1:0]                out_cnt;
   logic                         out_last;
   logic                         out_valid;
   logic                         out_ready;

   // master is the environment around the packer; slave is the packer itself
   modport master (
      output in_data, in_mask, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_cnt, out_last, out_valid
   );
   modport slave (
      input  in_data, in_mask, in_last, in_valid, out_ready,
      output in_ready, out_data, out_cnt, out_last, out_valid
   );
endinterface

// File: rtl/lane_packer.sv
// Compacts masked input lanes into dense N-word beats, flushing a partial (possibly empty) beat at packet end.
// Define LANE_PACKER_STATS_EN to add the stat_words / stat_pkts counters.
`timescale 1ns/1ps
module lane_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   lane_packer_if.slave  bus
`ifdef LANE_PACKER_STATS_EN
   ,
   output logic [31:0]   stat_words,
   output logic [15:0]   stat_pkts
`endif
);
   localparam int CW  = $clog2(N + 1);
   localparam int AD  = 2 * N - 1;
   localparam int ACW = $clog2(2 * N);
   localparam logic [ACW-1:0] N_A  = ACW'(N);
   localparam logic [ACW:0]   AD_E = (ACW + 1)'(AD);

   logic [DATA_WIDTH-1:0] acc_q [0:AD-1];
   logic [DATA_WIDTH-1:0] acc_d [0:AD-1];
   logic [ACW-1:0]        acc_cnt_q, acc_cnt_d;
   logic                  flush_pend_q, flush_pend_d;
   logic                  push, pop;
   logic [CW-1:0]         pop_cnt;
   logic [ACW-1:0]        pos;
   logic [ACW:0]          src;

   // Outputs depend on registers only, so in_ready has no path from out_ready.
   always_comb begin
      bus.in_ready  = (acc_cnt_q < N_A) && !flush_pend_q;
      bus.out_valid = (acc_cnt_q >= N_A) || flush_pend_q;
      bus.out_cnt   = (acc_cnt_q >= N_A) ? CW'(N) : acc_cnt_q[CW-1:0];
      bus.out_last  = flush_pend_q && (acc_cnt_q <= N_A);
      for (int i = 0; i < N; i++) begin
         bus.out_data[i] = acc_q[i];
      end
   end

   always_comb begin
      push    = bus.in_valid && bus.in_ready;
      pop     = bus.out_valid && bus.out_ready;
      pop_cnt = pop ? bus.out_cnt : '0;
      src     = '0;
      for (int i = 0; i < AD; i++) begin
         src      = (ACW + 1)'(i) + (ACW + 1)'(pop_cnt);
         acc_d[i] = (src < AD_E) ? acc_q[src[ACW-1:0]] : '0;
      end
      // Shift first, then append the compacted lanes behind the survivors.
      pos = acc_cnt_q - ACW'(pop_cnt);
      if (push) begin
         for (int j = 0; j < N; j++) begin
            if (bus.in_mask[j]) begin
               acc_d[pos] = bus.in_data[j];
               pos        = pos + ACW'(1);
            end
         end
      end
      acc_cnt_d    = pos;
      flush_pend_d = flush_pend_q;
      if (pop && bus.out_last) begin
         flush_pend_d = 1'b0;
      end
      if (push && bus.in_last) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < AD; i++) begin
            acc_q[i] <= '0;
         end
         acc_cnt_q    <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

`ifdef LANE_PACKER_STATS_EN
   logic [31:0] stat_words_q, stat_words_d;
   logic [15:0] stat_pkts_q, stat_pkts_d;
   logic [32:0] words_sum;

   always_comb begin
      words_sum    = {1'b0, stat_words_q} + 33'(pop_cnt);
      stat_words_d = words_sum[32] ? '1 : words_sum[31:0];
      stat_pkts_d  = (pop && bus.out_last) ? stat_pkts_q + 16'd1 : stat_pkts_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words_q <= '0;
         stat_pkts_q  <= '0;
      end else begin
         stat_words_q <= stat_words_d;
         stat_pkts_q  <= stat_pkts_d;
      end
   end

   assign stat_words = stat_words_q;
   assign stat_pkts  = stat_pkts_q;
`endif
endmodule
